// File: rtl/hg_pipe_axil_pkg.sv
// Shared types and constants for the HG_PIPE AXI4-Lite control register file.
package hg_pipe_axil_pkg;

   localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
   localparam int unsigned NUM_REGS        = 4;
   localparam int unsigned ADDR_LSB        = 2;

   typedef logic [31:0] axil_word_t;
   typedef logic [1:0]  reg_idx_t;

   // Replace only the bytes whose strobe bit is set.
   function automatic axil_word_t merge_strb(input axil_word_t old_word,
                                             input axil_word_t new_word,
                                             input logic [3:0] strb);
      axil_word_t res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/hg_pipe_s00_axi_regs_if.sv
// AXI4-Lite bus bundle for the S00_AXI control port.
interface hg_pipe_s00_axi_regs_if;
   import hg_pipe_axil_pkg::*;

   logic [3:0] awaddr;
   logic [2:0] awprot;
   logic       awvalid;
   logic       awready;
   axil_word_t wdata;
   logic [3:0] wstrb;
   logic       wvalid;
   logic       wready;
   logic [1:0] bresp;
   logic       bvalid;
   logic       bready;
   logic [3:0] araddr;
   logic [2:0] arprot;
   logic       arvalid;
   logic       arready;
   axil_word_t rdata;
   logic [1:0] rresp;
   logic       rvalid;
   logic       rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/hg_pipe_axil_wr_join.sv
// Joins independently arriving AW and W beats into one commit strobe and owns bvalid.
module hg_pipe_axil_wr_join
   import hg_pipe_axil_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rst_done_i,
   input  logic       aw_valid_i,
   input  reg_idx_t   aw_idx_i,
   output logic       aw_ready_o,
   input  logic       w_valid_i,
   input  axil_word_t w_data_i,
   input  logic [3:0] w_strb_i,
   output logic       w_ready_o,
   input  logic       b_ready_i,
   output logic       b_valid_o,
   output logic       commit_o,
   output reg_idx_t   commit_idx_o,
   output axil_word_t commit_data_o,
   output logic [3:0] commit_strb_o
);

   logic       aw_held_q, aw_held_d;
   reg_idx_t   aw_idx_q, aw_idx_d;
   logic       w_held_q, w_held_d;
   axil_word_t w_data_q, w_data_d;
   logic [3:0] w_strb_q, w_strb_d;
   logic       b_valid_q, b_valid_d;
   logic       aw_hs, w_hs;

   // Handshakes, commit detection and next-state of the holding flags / bvalid.
   always_comb begin
      aw_ready_o    = rst_done_i & ~aw_held_q & ~b_valid_q;
      w_ready_o     = rst_done_i & ~w_held_q & ~b_valid_q;
      aw_hs         = aw_valid_i & aw_ready_o;
      w_hs          = w_valid_i & w_ready_o;
      commit_o      = (aw_held_q | aw_hs) & (w_held_q | w_hs);
      commit_idx_o  = aw_held_q ? aw_idx_q : aw_idx_i;
      commit_data_o = w_held_q ? w_data_q : w_data_i;
      commit_strb_o = w_held_q ? w_strb_q : w_strb_i;

      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      b_valid_d = b_valid_q;

      if (b_valid_q && b_ready_i) b_valid_d = 1'b0;
      if (commit_o) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         b_valid_d = 1'b1;
      end else begin
         if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = aw_idx_i;
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = w_data_i;
            w_strb_d = w_strb_i;
         end
      end
   end

   assign b_valid_o = b_valid_q;

   // State registers; reset discards any half-received write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_q <= 1'b0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         b_valid_q <= b_valid_d;
      end
   end

endmodule

// File: rtl/hg_pipe_s00_axi_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the HG_PIPE fabric.
module hg_pipe_s00_axi_regs
   import hg_pipe_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                     s00_axi_aclk,
   input  logic                     s00_axi_aresetn,
   hg_pipe_s00_axi_regs_if.slave    s00_axi,
   output logic [NUM_REGS*32-1:0]   slv_reg_o,
   output logic [NUM_REGS-1:0]      slv_wr_pulse_o
);

   if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("hg_pipe_s00_axi_regs supports only 32-bit data");
   end
   if (C_S_AXI_ADDR_WIDTH != 4) begin : g_bad_addr_width
      $error("hg_pipe_s00_axi_regs supports only 4-bit addresses");
   end

   logic                rst_done_q;
   axil_word_t          reg_q [NUM_REGS];
   axil_word_t          reg_d [NUM_REGS];
   logic [NUM_REGS-1:0] pulse_q, pulse_d;
   logic                rvalid_q, rvalid_d;
   axil_word_t          rdata_q, rdata_d;
   logic                ar_hs;
   logic                commit;
   reg_idx_t            commit_idx;
   axil_word_t          commit_data;
   logic [3:0]          commit_strb;
   logic                unused_axi;

   // Protection bits and sub-word address bits carry no meaning here.
   assign unused_axi = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

   hg_pipe_axil_wr_join u_wr_join (
      .clk_i         (s00_axi_aclk),
      .rst_ni        (s00_axi_aresetn),
      .rst_done_i    (rst_done_q),
      .aw_valid_i    (s00_axi.awvalid),
      .aw_idx_i      (s00_axi.awaddr[ADDR_LSB +: 2]),
      .aw_ready_o    (s00_axi.awready),
      .w_valid_i     (s00_axi.wvalid),
      .w_data_i      (s00_axi.wdata),
      .w_strb_i      (s00_axi.wstrb),
      .w_ready_o     (s00_axi.wready),
      .b_ready_i     (s00_axi.bready),
      .b_valid_o     (s00_axi.bvalid),
      .commit_o      (commit),
      .commit_idx_o  (commit_idx),
      .commit_data_o (commit_data),
      .commit_strb_o (commit_strb)
   );

   assign s00_axi.bresp   = AXI_RESP_OKAY;
   assign s00_axi.rresp   = AXI_RESP_OKAY;
   assign s00_axi.arready = rst_done_q & ~rvalid_q;
   assign s00_axi.rvalid  = rvalid_q;
   assign s00_axi.rdata   = rdata_q;
   assign slv_wr_pulse_o  = pulse_q;
   assign ar_hs           = s00_axi.arvalid & s00_axi.arready;

   // Register writes, write pulses and read capture (reads see pre-write contents).
   always_comb begin
      reg_d   = reg_q;
      pulse_d = '0;
      if (commit) begin
         reg_d[commit_idx]   = merge_strb(reg_q[commit_idx], commit_data, commit_strb);
         pulse_d[commit_idx] = 1'b1;
      end
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (rvalid_q && s00_axi.rready) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = reg_q[s00_axi.araddr[ADDR_LSB +: 2]];
      end
   end

   // Flatten the register array, reg0 in the low word.
   always_comb begin
      slv_reg_o = '0;
      for (int i = 0; i < NUM_REGS; i++) slv_reg_o[32*i +: 32] = reg_q[i];
   end

   // State registers; rst_done holds all readies low for the first cycle after reset.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         rst_done_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
         pulse_q    <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         rst_done_q <= 1'b1;
         reg_q      <= reg_d;
         pulse_q    <= pulse_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_hg_pipe_s00_axi_regs.sv
// Self-checking bench for the S00_AXI register file: directed cases plus random traffic.
module tb_hg_pipe_s00_axi_regs;
   import hg_pipe_axil_pkg::*;

   localparam int Budget = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hg_pipe_s00_axi_regs_if bus ();
   logic [127:0] slv_reg;
   logic [3:0]   wr_pulse;

   hg_pipe_s00_axi_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi         (bus.slave),
      .slv_reg_o       (slv_reg),
      .slv_wr_pulse_o  (wr_pulse)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] model [4];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles, expected handshake", tag, Budget);
   endtask

   function automatic logic [127:0] model_flat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   // Byte-lane update of the reference model.
   task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   // All channel tasks start and end one time unit after a rising edge.
   task automatic do_aw(input logic [3:0] addr, input int dly);
      int n;
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1;
      end
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.awready && n < Budget) begin
         n++;
         @(negedge clk);
      end
      if (!bus.awready) timeout_fail("aw_hs");
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
      int n;
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1;
      end
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < Budget) begin
         n++;
         @(negedge clk);
      end
      if (!bus.wready) timeout_fail("w_hs");
      @(posedge clk);
      #1;
      bus.wvalid = 1'b0;
   endtask

   // Expects bready=1; checks response, pulse, exported registers and pulse width.
   task automatic wait_b(input logic [1:0] idx);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.bvalid && n < Budget) begin
         n++;
         @(negedge clk);
      end
      if (!bus.bvalid) timeout_fail("b_valid");
      check_eq("b_resp", 128'(bus.bresp), 128'(2'b00));
      check_eq("wr_pulse", 128'(wr_pulse), 128'(4'b0001 << idx));
      check_eq("slv_reg", slv_reg, model_flat());
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("b_drop", 128'(bus.bvalid), 128'(1'b0));
      check_eq("pulse_drop", 128'(wr_pulse), 128'(4'b0000));
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
      model_write(addr, data, strb);
      fork
         do_aw(addr, aw_dly);
         do_w(data, strb, w_dly);
      join
      wait_b(addr[3:2]);
   endtask

   // Expects rready=1.
   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
      int n;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.arready && n < Budget) begin
         n++;
         @(negedge clk);
      end
      if (!bus.arready) timeout_fail("ar_hs");
      @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
      @(negedge clk);
      check_eq("r_valid", 128'(bus.rvalid), 128'(1'b1));
      check_eq("r_data", 128'(bus.rdata), 128'(exp));
      check_eq("r_resp", 128'(bus.rresp), 128'(2'b00));
      check_eq("ar_busy", 128'(bus.arready), 128'(1'b0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      for (int i = 0; i < 4; i++) model[i] = '0;

      // Reset state and ready gating after release.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_regs", slv_reg, 128'(0));
      check_eq("rst_valids", 128'({bus.bvalid, bus.rvalid}), 128'(0));
      check_eq("rst_readies", 128'({bus.awready, bus.wready, bus.arready}), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rdy_gated", 128'({bus.awready, bus.wready, bus.arready}), 128'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rdy_up", 128'({bus.awready, bus.wready, bus.arready}), 128'(3'b111));
      @(posedge clk);
      #1;

      // Four registers written then read back in order.
      for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 32'(i + 1));

      // Byte strobes.
      axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0);
      axi_write(4'h4, 32'h1234_5678, 4'b0101, 0, 0);
      axi_read(4'h4, 32'hFF34_FF78);

      // AW alone, W three cycles later.
      model_write(4'h8, 32'hA5A5_A5A5, 4'hF);
      bus.awaddr  = 4'h8;
      bus.awvalid = 1'b1;
      @(negedge clk);
      check_eq("aw_first_rdy", 128'(bus.awready), 128'(1'b1));
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("aw_held_nob", 128'(bus.bvalid), 128'(1'b0));
         check_eq("aw_held_busy", 128'(bus.awready), 128'(1'b0));
         @(posedge clk);
         #1;
      end
      do_w(32'hA5A5_A5A5, 4'hF, 0);
      wait_b(2'd2);
      axi_read(4'h8, 32'hA5A5_A5A5);

      // B back-pressure blocks further writes until the handshake.
      bus.bready = 1'b0;
      model_write(4'hC, 32'hDEAD_BEEF, 4'hF);
      fork
         do_aw(4'hC, 0);
         do_w(32'hDEAD_BEEF, 4'hF, 0);
      join
      bus.awaddr  = 4'h4;
      bus.awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) check_eq("bp_pulse", 128'(wr_pulse), 128'(4'b1000));
         check_eq("bp_bvalid", 128'(bus.bvalid), 128'(1'b1));
         check_eq("bp_readies", 128'({bus.awready, bus.wready}), 128'(2'b00));
         @(posedge clk);
         #1;
      end
      check_eq("bp_reg3", slv_reg, model_flat());
      bus.bready = 1'b1;
      @(negedge clk);
      check_eq("bp_b_hs", 128'(bus.bvalid), 128'(1'b1));
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("bp_aw_again", 128'({bus.bvalid, bus.awready}), 128'(2'b01));
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      model_write(4'h4, 32'h0000_0055, 4'hF);
      do_w(32'h0000_0055, 4'hF, 0);
      wait_b(2'd1);

      // Same-edge read and write to register 0 returns the old value.
      axi_write(4'h0, 32'h11, 4'hF, 0, 0);
      fork
         axi_read(4'h0, 32'h11);
         axi_write(4'h0, 32'h22, 4'hF, 0, 0);
      join
      axi_read(4'h0, 32'h22);

      // Randomized traffic, including unaligned addresses and channel skew.
      for (int it = 0; it < 40; it++) begin
         logic [3:0] a;
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read(a, model[a[3:2]]);
      end

      // Reset with a read response pending and an AW held.
      bus.rready  = 1'b0;
      bus.araddr  = 4'h0;
      bus.arvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.arvalid = 1'b0;
      bus.awaddr  = 4'h8;
      bus.awvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) model[i] = '0;
      check_eq("mid_rst_valids", 128'({bus.rvalid, bus.bvalid}), 128'(0));
      check_eq("mid_rst_regs", slv_reg, 128'(0));
      check_eq("mid_rst_rdy", 128'({bus.awready, bus.wready, bus.arready}), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.rready = 1'b1;
      @(negedge clk);
      check_eq("rel_gated", 128'({bus.awready, bus.wready, bus.arready}), 128'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq("rel_up", 128'({bus.awready, bus.wready, bus.arready}), 128'(3'b111));
      @(posedge clk);
      #1;
      // A W alone must not pair with the discarded AW.
      model_write(4'h4, 32'h0000_0077, 4'hF);
      do_w(32'h0000_0077, 4'hF, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("discard_nob", 128'(bus.bvalid), 128'(1'b0));
         @(posedge clk);
         #1;
      end
      do_aw(4'h4, 0);
      wait_b(2'd1);
      axi_read(4'h8, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
